instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch-side initiator for the combinational Instruction_Memory. Owns the fetch
//  PC, drives the memory address, and captures the returned word into a small
//  instruction queue. Presents {pc, instr} to decode over a valid/ready
//  handshake. Accepts branch/jump redirects, which flush the queue.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch PC loaded on reset
//  QDEPTH    2              instruction queue entries (>=1, power of 2)
//  NOP_INSTR 32'h0000_0013  word presented on if_instr when the queue is empty
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   synchronous, active-high reset
//  fetch_en        in   1   1 = fetching allowed; 0 = hold PC, no new pushes
//  imem_addr       out  32  byte address to memory; always equals fetch_pc
//  imem_rdata      in   32  memory word; valid in the same cycle (no latency)
//  redirect_valid  in   1   1 = load redirect_pc and flush the queue
//  redirect_pc     in   32  target byte address; bits [1:0] ignored (forced 0)
//  if_valid        out  1   queue head holds a valid instruction
//  if_ready        in   1   decode accepts the head this cycle
//  if_instr        out  32  head instruction word; NOP_INSTR when !if_valid
//  if_pc           out  32  byte address of the head; 0 when !if_valid
// BEHAVIOUR
//  - Reset (rst high at an edge): fetch_pc=RESET_PC; count=0; rd/wr ptrs=0.
//    Outputs after reset: imem_addr=RESET_PC, if_valid=0, if_instr=NOP_INSTR,
//    if_pc=0. Reset mid-operation discards every queue entry and any redirect.
//  - pop  = if_valid & if_ready.
//  - push = fetch_en & !redirect_valid & (count<QDEPTH | pop).
//    On push: entry {fetch_pc, imem_rdata} is written at wr_ptr, and
//    fetch_pc <= fetch_pc+4.
//  - Push and pop in the same cycle: count is unchanged. A push while full is
//    legal only together with a pop.
//  - fetch_pc is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
//  - if_valid = (count!=0). The head is registered, so an instruction is
//    visible one cycle after it is pushed.
//  - Startup latency: with fetch_en high, the first cycle after reset pushes
//    RESET_PC, and if_valid is 1 in the next cycle.
//  - Redirect (highest priority below rst): at the edge, count<=0, pointers<=0,
//    fetch_pc<={redirect_pc[31:2],2'b00}. That cycle's push is suppressed.
//    A pop in that cycle is still a completed handshake from decode's view.
//    Redirect-to-valid latency is 2 cycles: cycle n+1 pushes the target, and
//    cycle n+2 shows if_valid=1 with if_pc=target.
//  - Back-to-back redirects: the last one wins; no push occurs while
//    redirect_valid is high.
//  - fetch_en low: no pushes, fetch_pc holds, pops continue until the queue is
//    empty. Redirect is still honoured.
//  - if_ready low with the queue full: fetch_pc holds and the head is stable
//    (if_instr and if_pc do not change while if_valid & !if_ready).
//  - Steady state with if_ready held high: one instruction per cycle.
//  - State: fetch_pc, count (0..QDEPTH), rd_ptr, wr_ptr, QDEPTH x 64-bit
//    entries. No other FSM.
// TESTING
//  Bench memory model: 0x0=32'h00100093, 0x4=32'h00200113, 0x8=32'h002081B3;
//  all other locations hold NOP.
//  1 Reset release, fetch_en=1, if_ready=1 -> cycle 1: if_valid=1,
//    if_pc=0x0, if_instr=32'h00100093; then pc 0x4 and 0x8 on consecutive
//    cycles.
//  2 if_ready=0 for 5 cycles -> count saturates at QDEPTH; imem_addr holds at
//    0x8; if_pc stays 0x0. On release, 0x4 and 0x8 follow with no bubble.
//  3 redirect_valid for 1 cycle, redirect_pc=0x0000_0023 -> next cycle
//    if_valid=0 and imem_addr=0x20; the cycle after, if_pc=0x20 and
//    if_instr=NOP_INSTR.
//  4 redirect_valid in the same cycle as a pop with the queue full -> queue
//    empty after the edge; no stale PC ever appears on if_pc.
//  5 redirect_pc=32'hFFFF_FFFC, run 2 fetches -> if_pc sequence FFFF_FFFC,
//    0000_0000.
//  6 rst asserted for 1 cycle mid-stream with the queue full -> next cycle
//    if_valid=0 and imem_addr=RESET_PC; fetch restarts cleanly.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, drives the combinational
// instruction memory, and buffers fetched {pc, instr} pairs in a small
// circular queue whose head is presented to decode over valid/ready.
// A redirect reloads the PC (word aligned) and flushes the queue.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned QDEPTH    = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    // A one-entry queue still needs a 1-bit pointer so the indexing stays legal.
    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

    logic [31:0]      fetchPc_q, fetchPc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [63:0]      entries_q [QDEPTH];

    logic        pop;
    logic        push;
    logic        notEmpty;
    logic [63:0] headEntry;

    // Pointers wrap explicitly so the queue works for any depth.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign notEmpty  = (count_q != '0);
    assign headEntry = entries_q[rdPtr_q];

    // Memory is addressed straight from the fetch PC; the head is a pure
    // function of registered state, so decode sees a stable word while stalled.
    assign imem_addr = fetchPc_q;
    assign if_valid  = notEmpty;
    assign if_pc     = notEmpty ? headEntry[63:32] : 32'h0000_0000;
    assign if_instr  = notEmpty ? headEntry[31:0]  : NOP_INSTR;

    // A push into a full queue is only allowed when the head leaves this cycle.
    assign pop  = notEmpty & if_ready;
    assign push = fetch_en & ~redirect_valid & ((count_q != CNT_FULL) | pop);

    // Next-state for PC, occupancy and pointers; a redirect overrides everything
    // and its target is forced onto a word boundary.
    always_comb begin
        fetchPc_d = fetchPc_q;
        count_d   = count_q;
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        if (redirect_valid) begin
            fetchPc_d = redirect_pc & 32'hFFFF_FFFC;
            count_d   = '0;
            rdPtr_d   = '0;
            wrPtr_d   = '0;
        end else begin
            if (push) begin
                fetchPc_d = fetchPc_q + 32'd4;
                wrPtr_d   = ptrInc(wrPtr_q);
            end
            if (pop) begin
                rdPtr_d = ptrInc(rdPtr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset back to the boot PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q <= RESET_PC;
            count_q   <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            count_q   <= count_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
        end
    end

    // Queue storage captures {pc, word} at the write pointer; contents need no
    // reset because occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            entries_q[wrPtr_q] <= {fetchPc_q, imem_rdata};
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: a table of per-cycle vectors with
// hand-derived expectations, hand-written corner sequences, and a random
// phase, all cross-checked every cycle against a queue-based scoreboard.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetchEn;
   logic        ifReady;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic [31:0] imemAddr;
   logic [31:0] imemRdata;
   logic        ifValid;
   logic [31:0] ifInstr;
   logic [31:0] ifPc;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [63:0] sbQueue [$];
   logic [31:0] modelPc;

   typedef struct {
      string       name;
      logic        rst;
      logic        en;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        expV;
      logic [31:0] expPc;
      logic [31:0] expInstr;
      logic [31:0] expAddr;
   } vector_t;

   vector_t vecs [$];

   instruction_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (2),
      .NOP_INSTR(NOP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_en      (fetchEn),
      .imem_addr     (imemAddr),
      .imem_rdata    (imemRdata),
      .redirect_valid(redirectValid),
      .redirect_pc   (redirectPc),
      .if_valid      (ifValid),
      .if_ready      (ifReady),
      .if_instr      (ifInstr),
      .if_pc         (ifPc)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Bench memory contents; everything not listed reads as NOP.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0010_0093;
         32'h0000_0004: return 32'h0020_0113;
         32'h0000_0008: return 32'h0020_81B3;
         default:       return NOP;
      endcase
   endfunction

   // Zero-latency memory answering whatever address the DUT drives.
   assign imemRdata = memWord(imemAddr);

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: advanced once per cycle from the inputs about to be
   // clocked, pushing the expected {pc, instr} pairs into the scoreboard.
   task automatic modelStep();
      logic        popE;
      logic        pushE;
      logic [63:0] dropped;
      popE  = (sbQueue.size() != 0) && ifReady;
      pushE = fetchEn && !redirectValid && ((sbQueue.size() < 2) || popE);
      if (rst) begin
         sbQueue.delete();
         modelPc = 32'h0000_0000;
      end else if (redirectValid) begin
         sbQueue.delete();
         modelPc = redirectPc & 32'hFFFF_FFFC;
      end else begin
         if (popE) dropped = sbQueue.pop_front();
         if (pushE) begin
            sbQueue.push_back({modelPc, memWord(modelPc)});
            modelPc = modelPc + 32'd4;
         end
      end
   endtask

   // Compare DUT outputs with the scoreboard head after each edge.
   task automatic scoreboardCheck();
      logic        expV;
      logic [31:0] expPc;
      logic [31:0] expInstr;
      expV     = (sbQueue.size() != 0);
      expPc    = expV ? sbQueue[0][63:32] : 32'h0000_0000;
      expInstr = expV ? sbQueue[0][31:0]  : NOP;
      compare("sb_valid", {31'b0, ifValid}, {31'b0, expV});
      compare("sb_pc",    ifPc,     expPc);
      compare("sb_instr", ifInstr,  expInstr);
      compare("sb_addr",  imemAddr, modelPc);
   endtask

   // Drive one cycle of inputs, clock it, and check against the scoreboard.
   task automatic applyStimulus(input logic r, input logic e, input logic y,
                                input logic v, input logic [31:0] p);
      rst           = r;
      fetchEn       = e;
      ifReady       = y;
      redirectValid = v;
      redirectPc    = p;
      modelStep();
      @(posedge clk);
      #1;
      scoreboardCheck();
   endtask

   // Compare DUT outputs with hand-derived values.
   task automatic checkOutput(input string name, input logic expV, input logic [31:0] expPc,
                              input logic [31:0] expInstr, input logic [31:0] expAddr);
      compare({name, "_valid"}, {31'b0, ifValid}, {31'b0, expV});
      compare({name, "_pc"},    ifPc,     expPc);
      compare({name, "_instr"}, ifInstr,  expInstr);
      compare({name, "_addr"},  imemAddr, expAddr);
   endtask

   task automatic addVec(input string n, input logic r, input logic e, input logic y,
                         input logic v, input logic [31:0] p, input logic ev,
                         input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ea);
      vector_t t;
      t.name = n; t.rst = r; t.en = e; t.rdy = y; t.redir = v; t.rpc = p;
      t.expV = ev; t.expPc = epc; t.expInstr = ei; t.expAddr = ea;
      vecs.push_back(t);
   endtask

   initial begin
      rst = 1'b1; fetchEn = 1'b0; ifReady = 1'b0; redirectValid = 1'b0; redirectPc = '0;
      modelPc = '0;

      //     name        rst en rdy rv rpc            v  pc             instr          addr
      addVec("reset",     1, 1, 1, 0, 32'h0,         0, 32'h0,         NOP,           32'h0);
      addVec("start0",    0, 1, 1, 0, 32'h0,         1, 32'h0,         32'h00100093,  32'h4);
      addVec("start1",    0, 1, 1, 0, 32'h0,         1, 32'h4,         32'h00200113,  32'h8);
      addVec("start2",    0, 1, 1, 0, 32'h0,         1, 32'h8,         32'h002081B3,  32'hC);
      addVec("reset2",    1, 1, 1, 0, 32'h0,         0, 32'h0,         NOP,           32'h0);
      addVec("stall0",    0, 1, 0, 0, 32'h0,         1, 32'h0,         32'h00100093,  32'h4);
      addVec("stall1",    0, 1, 0, 0, 32'h0,         1, 32'h0,         32'h00100093,  32'h8);
      addVec("stall2",    0, 1, 0, 0, 32'h0,         1, 32'h0,         32'h00100093,  32'h8);
      addVec("stall3",    0, 1, 0, 0, 32'h0,         1, 32'h0,         32'h00100093,  32'h8);
      addVec("stall4",    0, 1, 0, 0, 32'h0,         1, 32'h0,         32'h00100093,  32'h8);
      addVec("release0",  0, 1, 1, 0, 32'h0,         1, 32'h4,         32'h00200113,  32'hC);
      addVec("release1",  0, 1, 1, 0, 32'h0,         1, 32'h8,         32'h002081B3,  32'h10);
      addVec("release2",  0, 1, 1, 0, 32'h0,         1, 32'hC,         NOP,           32'h14);
      addVec("redir23",   0, 1, 1, 1, 32'h23,        0, 32'h0,         NOP,           32'h20);
      addVec("redirTgt",  0, 1, 1, 0, 32'h0,         1, 32'h20,        NOP,           32'h24);
      addVec("fill0",     0, 1, 0, 0, 32'h0,         1, 32'h20,        NOP,           32'h28);
      addVec("fill1",     0, 1, 0, 0, 32'h0,         1, 32'h20,        NOP,           32'h28);
      addVec("redirPop",  0, 1, 1, 1, 32'h4,         0, 32'h0,         NOP,           32'h4);
      addVec("afterRd0",  0, 1, 1, 0, 32'h0,         1, 32'h4,         32'h00200113,  32'h8);
      addVec("afterRd1",  0, 1, 1, 0, 32'h0,         1, 32'h8,         32'h002081B3,  32'hC);
      addVec("enLowHold", 0, 0, 0, 0, 32'h0,         1, 32'h8,         32'h002081B3,  32'hC);
      addVec("enLowPop",  0, 0, 1, 0, 32'h0,         0, 32'h0,         NOP,           32'hC);
      addVec("enLowRedir",0, 0, 1, 1, 32'h100,       0, 32'h0,         NOP,           32'h100);
      addVec("b2bRedir",  0, 1, 1, 1, 32'h8,         0, 32'h0,         NOP,           32'h8);
      addVec("b2bTgt",    0, 1, 1, 0, 32'h0,         1, 32'h8,         32'h002081B3,  32'hC);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
         checkOutput(vecs[i].name, vecs[i].expV, vecs[i].expPc, vecs[i].expInstr, vecs[i].expAddr);
      end

      // PC wrap: redirect near the top of the address space, low bits dropped.
      applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFF);
      checkOutput("wrapRedir", 0, 32'h0, NOP, 32'hFFFF_FFFC);
      applyStimulus(0, 1, 1, 0, 32'h0);
      checkOutput("wrapTop", 1, 32'hFFFF_FFFC, NOP, 32'h0);
      applyStimulus(0, 1, 1, 0, 32'h0);
      checkOutput("wrapZero", 1, 32'h0, 32'h00100093, 32'h4);

      // Reset in the middle of a full, stalled queue.
      applyStimulus(0, 1, 0, 0, 32'h0);
      applyStimulus(0, 1, 0, 0, 32'h0);
      checkOutput("fullBeforeRst", 1, 32'h0, 32'h00100093, 32'h8);
      applyStimulus(1, 1, 0, 1, 32'h40);
      checkOutput("midRst", 0, 32'h0, NOP, 32'h0);
      applyStimulus(0, 1, 1, 0, 32'h0);
      checkOutput("rstRestart", 1, 32'h0, 32'h00100093, 32'h4);

      // Random traffic checked only by the scoreboard.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] tgt;
         case ($urandom_range(0, 3))
            0:       tgt = 32'h0;
            1:       tgt = 32'h4;
            2:       tgt = 32'hFFFF_FFF8;
            default: tgt = $urandom();
         endcase
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
                       $urandom_range(0, 4) < 3, $urandom_range(0, 19) == 0, tgt);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
